// File: rtl/mioc_z80_pkg.sv
// mioc_z80_pkg: command-type and bus-cycle state encodings shared by the Z80 bus master blocks.
package mioc_z80_pkg;
  typedef enum logic [2:0] {
    CMD_M1   = 3'd0,
    CMD_MRD  = 3'd1,
    CMD_MWR  = 3'd2,
    CMD_IORD = 3'd3,
    CMD_IOWR = 3'd4
  } cmd_t;
  typedef enum logic [3:0] {IDLE, T1, T2, TWA, TW, T3, T4, BUSGNT, ILL} state_t;
  localparam logic [7:0] ILL_RDATA = 8'hFF;
  function automatic logic cmd_legal(input logic [2:0] t);
    return t <= 3'd4;
  endfunction
endpackage

// File: rtl/z80_rfsh_cnt.sv
// z80_rfsh_cnt: 7-bit refresh register, wraps 127 -> 0.
module z80_rfsh_cnt (
  input  logic       clk,
  input  logic       clr,
  input  logic       inc,
  output logic [6:0] cnt
);
  always_ff @(posedge clk)
    if (clr) cnt <= '0;
    else if (inc) cnt <= cnt + 7'd1;
endmodule

// File: rtl/z80_bus_master.sv
// z80_bus_master: Z80 bus-cycle sequencer for M1, memory and I/O cycles with refresh and bus grant.
module z80_bus_master
  import mioc_z80_pkg::*;
(
  input  logic        B_PHI,
  input  logic        RESET,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic [2:0]  CMD_TYPE,
  input  logic [15:0] CMD_ADDR,
  input  logic [7:0]  CMD_WDATA,
  output logic        RSP_VALID,
  output logic [7:0]  RSP_RDATA,
  output logic [15:0] BA,
  input  logic [7:0]  BD_IN,
  output logic [7:0]  BD_OUT,
  output logic        BD_OE,
  output logic        BMREQ_N,
  output logic        BRD_N,
  output logic        N_BWR,
  output logic        IORQ_N,
  output logic        BM1_N,
  output logic        BRFSH_N,
  input  logic        WAIT_N,
  input  logic        BUSRQ_N,
  output logic        BUSAK_N,
  output logic        BUS_OE
);
  state_t state, state_nx, start;
  logic [2:0] typ;
  logic [15:0] addr;
  logic [7:0] wdata;
  logic [6:0] r;
  logic m1, io, wr, accept, m1_cap, rd_cap, t13, t23, pre3, rfsh;

  assign m1 = typ == CMD_M1;
  assign io = typ == CMD_IORD || typ == CMD_IOWR;
  assign wr = typ == CMD_MWR || typ == CMD_IOWR;
  assign CMD_READY = BUSRQ_N && (state == IDLE || state == T4 || (state == T3 && !m1));
  assign accept = CMD_VALID && CMD_READY;
  // opcode fetch latches data on the edge that leaves the wait window
  assign m1_cap = m1 && state_nx == T3;
  assign rd_cap = state == T3 && (typ == CMD_MRD || typ == CMD_IORD);

  z80_rfsh_cnt u_rfsh (
    .clk(B_PHI),
    .clr(RESET),
    .inc(state == T4),
    .cnt(r)
  );

  always_ff @(posedge B_PHI)
    if (RESET) state <= IDLE;
    else state <= state_nx;

  // bus request wins over a pending command at every accept point
  always_comb begin
    start = !BUSRQ_N ? BUSGNT : !CMD_VALID ? IDLE : cmd_legal(CMD_TYPE) ? T1 : ILL;
    state_nx = IDLE;
    case (state)
      IDLE, T4: state_nx = start;
      T1:       state_nx = T2;
      T2:       state_nx = io ? TWA : WAIT_N ? T3 : TW;
      TWA, TW:  state_nx = WAIT_N ? T3 : TW;
      T3:       state_nx = m1 ? T4 : start;
      BUSGNT:   state_nx = BUSRQ_N ? IDLE : BUSGNT;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge B_PHI)
    if (RESET) begin
      typ <= '0;
      addr <= '0;
      wdata <= '0;
      RSP_VALID <= 1'b0;
      RSP_RDATA <= '0;
    end else begin
      if (accept) begin
        typ <= CMD_TYPE;
        addr <= CMD_ADDR;
        wdata <= CMD_WDATA;
      end
      RSP_VALID <= m1_cap || (state == T3 && !m1) || state == ILL;
      RSP_RDATA <= (m1_cap || rd_cap) ? BD_IN : state == ILL ? ILL_RDATA : RSP_RDATA;
    end

  always_comb begin
    t13 = state inside {T1, T2, TWA, TW, T3};
    t23 = state inside {T2, TWA, TW, T3};
    pre3 = m1 && state inside {T1, T2, TW};
    rfsh = m1 && state inside {T3, T4};
    BM1_N = !pre3;
    BMREQ_N = !(!io && (t13 || rfsh));
    BRD_N = !(pre3 || (typ == CMD_MRD && t13) || (typ == CMD_IORD && t23));
    N_BWR = !(wr && t23);
    IORQ_N = !(io && t23);
    BRFSH_N = !rfsh;
    BD_OE = wr && t13;
    BD_OUT = wdata;
    BA = rfsh ? {9'd0, r} : addr;
    BUSAK_N = state != BUSGNT;
    BUS_OE = state != BUSGNT;
  end
endmodule

// File: tb/tb_z80_bus_master.sv
// tb_z80_bus_master: random Z80 bus cycles checked cycle by cycle against a transaction-level expectation queue.
module tb_z80_bus_master;
  logic B_PHI = 1'b0, RESET = 1'b1, CMD_VALID = 1'b0, WAIT_N = 1'b1, BUSRQ_N = 1'b1;
  logic [2:0] CMD_TYPE = '0;
  logic [15:0] CMD_ADDR = '0;
  logic [7:0] CMD_WDATA = '0, BD_IN = '0;
  logic CMD_READY, RSP_VALID, BD_OE, BMREQ_N, BRD_N, N_BWR, IORQ_N, BM1_N, BRFSH_N, BUSAK_N, BUS_OE;
  logic [7:0] RSP_RDATA, BD_OUT;
  logic [15:0] BA;

  z80_bus_master dut (
    .B_PHI(B_PHI), .RESET(RESET), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_TYPE(CMD_TYPE), .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .BA(BA), .BD_IN(BD_IN),
    .BD_OUT(BD_OUT), .BD_OE(BD_OE), .BMREQ_N(BMREQ_N), .BRD_N(BRD_N),
    .N_BWR(N_BWR), .IORQ_N(IORQ_N), .BM1_N(BM1_N), .BRFSH_N(BRFSH_N),
    .WAIT_N(WAIT_N), .BUSRQ_N(BUSRQ_N), .BUSAK_N(BUSAK_N), .BUS_OE(BUS_OE)
  );

  always #5 B_PHI = ~B_PHI;

  // one expected bus cycle; stb is {M1,MREQ,RD,WR,IORQ,RFSH} active-low
  typedef struct packed {
    logic [5:0] stb;
    logic [15:0] ba;
    logic chk_ba;
    logic oe;
    logic [7:0] wd;
    logic rdy;
    logic gnt;
    logic wn;
    logic [7:0] din;
    logic rv;
    logic [7:0] rd;
  } cyc_t;

  cyc_t q[$];
  int checks = 0, errors = 0;
  logic pend_rv = 1'b0, p_rv = 1'b0, p_keep = 1'b0;
  logic [7:0] pend_rd = '0, exp_rd = '0, p_rd = '0;
  logic [6:0] r = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(1, 0));
  endfunction

  function automatic logic [7:0] rb8();
    return 8'($urandom);
  endfunction

  function automatic cyc_t idle_e(input logic gnt, input logic rdy);
    cyc_t e;
    e = '0;
    e.stb = 6'h3f;
    e.gnt = gnt;
    e.rdy = rdy;
    return e;
  endfunction

  task automatic add(input logic [5:0] lo, input logic [15:0] ba, input logic chk_ba, input logic oe,
                     input logic [7:0] wd, input logic rdy, input logic wn, input logic [7:0] din,
                     input logic rv, input logic [7:0] rd);
    cyc_t e;
    e.stb = ~lo;
    e.ba = ba;
    e.chk_ba = chk_ba;
    e.oe = oe;
    e.wd = wd;
    e.rdy = rdy;
    e.gnt = 1'b0;
    e.wn = wn;
    e.din = din;
    e.rv = rv;
    e.rd = rd;
    q.push_back(e);
  endtask

  // expands one command into its expected bus cycles from the cycle-type rules
  task automatic build(input logic [2:0] t, input logic [15:0] a, input logic [7:0] wd, input int nw,
                       input logic [7:0] din);
    logic [5:0] lo1, lo2;
    logic oe;
    q.delete();
    p_rv = 1'b1;
    p_keep = 1'b0;
    p_rd = din;
    oe = (t == 3'd2 || t == 3'd4);
    if (t > 3'd4) begin
      add(6'h00, a, 1'b0, 1'b0, wd, 1'b0, rb(), rb8(), 1'b0, 8'h00);
      add(6'h00, a, 1'b0, 1'b0, wd, 1'b1, rb(), rb8(), 1'b1, 8'hFF);
      p_rv = 1'b0;
      return;
    end
    lo1 = t == 3'd0 ? 6'b111000 : t == 3'd1 ? 6'b011000 : t == 3'd2 ? 6'b010000 : 6'b000000;
    lo2 = t == 3'd0 ? 6'b111000 : t == 3'd1 ? 6'b011000 : t == 3'd2 ? 6'b010100 :
          t == 3'd3 ? 6'b001010 : 6'b000110;
    p_keep = oe;
    add(lo1, a, 1'b1, oe, wd, 1'b0, rb(), rb8(), 1'b0, 8'h00);
    if (t >= 3'd3) add(lo2, a, 1'b1, oe, wd, 1'b0, rb(), rb8(), 1'b0, 8'h00);
    for (int i = 0; i <= nw; i++)
      add(lo2, a, 1'b1, oe, wd, 1'b0, i == nw, (t == 3'd0 && i == nw) ? din : rb8(), 1'b0, 8'h00);
    if (t == 3'd0) begin
      add(6'b010001, {9'd0, r}, 1'b1, 1'b0, wd, 1'b0, rb(), rb8(), 1'b1, din);
      add(6'b010001, {9'd0, r}, 1'b1, 1'b0, wd, 1'b1, rb(), rb8(), 1'b0, 8'h00);
      r = r + 7'd1;
      p_rv = 1'b0;
    end else
      add(lo2, a, 1'b1, oe, wd, 1'b1, rb(), (t == 3'd1 || t == 3'd3) ? din : rb8(), 1'b0, 8'h00);
  endtask

  task automatic chk_cyc(input cyc_t e);
    logic rv;
    rv = e.rv | pend_rv;
    if (pend_rv) exp_rd = pend_rd;
    if (e.rv) exp_rd = e.rd;
    pend_rv = 1'b0;
    check("strobes", 32'({BM1_N, BMREQ_N, BRD_N, N_BWR, IORQ_N, BRFSH_N}), 32'(e.stb));
    if (e.chk_ba) check("ba", 32'(BA), 32'(e.ba));
    check("bd_oe", 32'(BD_OE), 32'(e.oe));
    if (e.oe) check("bd_out", 32'(BD_OUT), 32'(e.wd));
    check("cmd_ready", 32'(CMD_READY), 32'(e.rdy));
    check("rsp_valid", 32'(RSP_VALID), 32'(rv));
    check("rsp_rdata", 32'(RSP_RDATA), 32'(exp_rd));
    check("busak_n", 32'(BUSAK_N), 32'(!e.gnt));
    check("bus_oe", 32'(BUS_OE), 32'(!e.gnt));
  endtask

  task automatic chk_reset();
    check("rst_strobes", 32'({BM1_N, BMREQ_N, BRD_N, N_BWR, IORQ_N, BRFSH_N}), 32'h3f);
    check("rst_ba", 32'(BA), 32'h0);
    check("rst_bd_out", 32'(BD_OUT), 32'h0);
    check("rst_bd_oe", 32'(BD_OE), 32'h0);
    check("rst_rsp_valid", 32'(RSP_VALID), 32'h0);
    check("rst_rsp_rdata", 32'(RSP_RDATA), 32'h0);
    check("rst_busak_n", 32'(BUSAK_N), 32'h1);
    check("rst_bus_oe", 32'(BUS_OE), 32'h1);
    check("rst_cmd_ready", 32'(CMD_READY), 32'h1);
    pend_rv = 1'b0;
    exp_rd = '0;
    r = '0;
  endtask

  // entered in a cycle where the DUT is ready; leaves in the command's last (ready) T-state
  task automatic run_cmd(input logic [2:0] t, input logic [15:0] a, input logic [7:0] wd, input int nw,
                         input logic [7:0] din);
    build(t, a, wd, nw, din);
    CMD_VALID = 1'b1;
    CMD_TYPE = t;
    CMD_ADDR = a;
    CMD_WDATA = wd;
    @(posedge B_PHI);
    #1;
    CMD_VALID = 1'b0;
    CMD_TYPE = 3'($urandom);
    CMD_ADDR = 16'($urandom);
    CMD_WDATA = rb8();
    foreach (q[i]) begin
      if (i > 0) begin
        @(posedge B_PHI);
        #1;
      end
      WAIT_N = q[i].wn;
      BD_IN = q[i].din;
      @(negedge B_PHI);
      chk_cyc(q[i]);
    end
    pend_rv = p_rv;
    pend_rd = p_keep ? exp_rd : p_rd;
  endtask

  task automatic idle(input int n);
    CMD_VALID = 1'b0;
    repeat (n) begin
      @(posedge B_PHI);
      #1;
      WAIT_N = rb();
      BD_IN = rb8();
      @(negedge B_PHI);
      chk_cyc(idle_e(1'b0, 1'b1));
    end
  endtask

  task automatic bus_grant(input int hold, input logic with_cmd);
    BUSRQ_N = 1'b0;
    CMD_VALID = with_cmd;
    CMD_TYPE = 3'd1;
    CMD_ADDR = 16'hBEEF;
    CMD_WDATA = 8'h00;
    #1;
    check("busrq_ready", 32'(CMD_READY), 32'h0);
    repeat (hold) begin
      @(posedge B_PHI);
      #1;
      @(negedge B_PHI);
      chk_cyc(idle_e(1'b1, 1'b0));
    end
    BUSRQ_N = 1'b1;
    @(posedge B_PHI);
    #1;
    @(negedge B_PHI);
    chk_cyc(idle_e(1'b0, 1'b1));
  endtask

  initial begin
    logic [2:0] t;
    repeat (2) @(posedge B_PHI);
    #1;
    RESET = 1'b0;
    @(negedge B_PHI);
    chk_reset();
    run_cmd(3'd0, 16'h2000, 8'h00, 0, 8'h3E);
    run_cmd(3'd1, 16'h6000, 8'h00, 2, rb8());
    idle(1);
    run_cmd(3'd4, 16'h00E0, 8'h0F, 0, rb8());
    idle(1);
    for (int i = 0; i < 128; i++)
      run_cmd(3'd0, 16'($urandom), rb8(), int'($urandom_range(1, 0)), rb8());
    idle(1);
    bus_grant(3, 1'b1);
    run_cmd(3'd1, 16'hBEEF, 8'h00, 1, rb8());
    bus_grant(2, 1'b0);
    run_cmd(3'd6, 16'h1111, 8'h22, 0, 8'h00);
    idle(1);
    CMD_VALID = 1'b1;
    CMD_TYPE = 3'd1;
    CMD_ADDR = 16'h4321;
    @(posedge B_PHI);
    #1;
    CMD_VALID = 1'b0;
    WAIT_N = 1'b0;
    repeat (2) begin
      @(posedge B_PHI);
      #1;
    end
    @(negedge B_PHI);
    check("tw_brd_n", 32'(BRD_N), 32'h0);
    check("tw_ba", 32'(BA), 32'h4321);
    RESET = 1'b1;
    @(posedge B_PHI);
    #1;
    RESET = 1'b0;
    WAIT_N = 1'b1;
    @(negedge B_PHI);
    chk_reset();
    idle(2);
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(9, 0))
        0: bus_grant(int'($urandom_range(3, 1)), 1'b0);
        1: idle(int'($urandom_range(3, 1)));
        default: ;
      endcase
      t = $urandom_range(9, 0) == 0 ? 3'($urandom_range(7, 5)) : 3'($urandom_range(4, 0));
      run_cmd(t, 16'($urandom), rb8(), int'($urandom_range(3, 0)), rb8());
    end
    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
